// File: rtl/timer_pkg.sv
// rtl/timer_pkg.sv - shared types and helpers for the multi-channel interval timer
package timer_pkg;

  localparam logic MODE_ONESHOT  = 1'b0;
  localparam logic MODE_PERIODIC = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } ch_state_e;

  // Prescaler counter width; a divide-by-1 still needs one bit of storage.
  function automatic int presc_width(input int presc);
    return (presc <= 1) ? 1 : $clog2(presc);
  endfunction

endpackage

// File: rtl/timer_channel.sv
// rtl/timer_channel.sv - one interval timer channel: IDLE/RUN FSM, one-shot or auto-reload
module timer_channel
  import timer_pkg::*;
#(
  parameter int WIDTH = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick,
  input  logic             start,
  input  logic             stop,
  input  logic             periodic,
  input  logic [WIDTH-1:0] load_value,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] count
);

  ch_state_e        state_q, state_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             mode_q, mode_d;
  logic             done_q, done_d;
  logic             at_term;

  assign at_term = (count_q == reload_q);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      reload_q <= '0;
      count_q  <= '0;
      mode_q   <= MODE_ONESHOT;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      reload_q <= reload_d;
      count_q  <= count_d;
      mode_q   <= mode_d;
      done_q   <= done_d;
    end
  end

  // stop beats start, start beats tick
  always_comb begin
    state_d = state_q;
    if (stop) begin
      state_d = ST_IDLE;
    end else if (start) begin
      state_d = ST_RUN;
    end else if (state_q == ST_RUN && tick && at_term && mode_q == MODE_ONESHOT) begin
      state_d = ST_IDLE;
    end
  end

  always_comb begin
    reload_d = reload_q;
    mode_d   = mode_q;
    count_d  = count_q;
    done_d   = 1'b0;
    if (stop) begin
      count_d = '0;
    end else if (start) begin
      reload_d = load_value;
      mode_d   = periodic;
      count_d  = '0;
    end else if (state_q == ST_RUN && tick) begin
      if (at_term) begin
        count_d = '0;
        done_d  = 1'b1;
      end else begin
        count_d = count_q + WIDTH'(1);
      end
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign done  = done_q;
  assign count = count_q;

endmodule

// File: rtl/multi_channel_timer.sv
// rtl/multi_channel_timer.sv - NUM_CH interval timers sharing one free-running prescaler
module multi_channel_timer
  import timer_pkg::*;
#(
  parameter int NUM_CH   = 2,
  parameter int WIDTH    = 13,
  parameter int PRESCALE = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NUM_CH-1:0]       start,
  input  logic [NUM_CH-1:0]       stop,
  input  logic [NUM_CH-1:0]       periodic,
  input  logic [NUM_CH*WIDTH-1:0] load_value,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       done,
  output logic [NUM_CH*WIDTH-1:0] count,
  output logic                    tick
);

  localparam int            PW       = presc_width(PRESCALE);
  localparam logic [PW-1:0] PRE_LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
    end
  end

  // Free-running, deliberately not aligned to any channel's start.
  always_comb begin
    tick_d = (pre_q == PRE_LAST);
    pre_d  = tick_d ? '0 : pre_q + PW'(1);
  end

  assign tick = tick_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    timer_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk       (clk),
      .reset     (reset),
      .tick      (tick_q),
      .start     (start[i]),
      .stop      (stop[i]),
      .periodic  (periodic[i]),
      .load_value(load_value[i*WIDTH +: WIDTH]),
      .busy      (busy[i]),
      .done      (done[i]),
      .count     (count[i*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_multi_channel_timer.sv
// tb/tb_multi_channel_timer.sv - randomized self-checking bench, prescale 1 and 4 instances
module tb_multi_channel_timer;

  logic        clk;
  logic        reset;
  logic [1:0]  start, stop, periodic;
  logic [15:0] load_value;
  logic [1:0]  busy_a, done_a, busy_b, done_b;
  logic [15:0] count_a, count_b;
  logic        tick_a, tick_b;

  multi_channel_timer #(.NUM_CH(2), .WIDTH(8), .PRESCALE(1)) dut_p1 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .periodic(periodic),
    .load_value(load_value), .busy(busy_a), .done(done_a), .count(count_a), .tick(tick_a)
  );

  multi_channel_timer #(.NUM_CH(2), .WIDTH(8), .PRESCALE(4)) dut_p4 (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .periodic(periodic),
    .load_value(load_value), .busy(busy_b), .done(done_b), .count(count_b), .tick(tick_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: per instance k (prescale 1/4) and channel i, ticks consumed since start.
  int presc [2] = '{1, 4};
  int edges;
  bit tick_m [2];
  bit act_m  [2][2];
  bit mode_m [2][2];
  bit done_m [2][2];
  int rel_m  [2][2];
  int n_m    [2][2];

  function automatic void model_reset();
    edges = 0;
    for (int k = 0; k < 2; k++) begin
      tick_m[k] = 1'b0;
      for (int i = 0; i < 2; i++) begin
        act_m[k][i] = 1'b0; mode_m[k][i] = 1'b0; done_m[k][i] = 1'b0;
        rel_m[k][i] = 0;    n_m[k][i] = 0;
      end
    end
  endfunction

  function automatic void model_step();
    edges++;
    for (int k = 0; k < 2; k++) begin
      bit tin;
      tin = tick_m[k];
      for (int i = 0; i < 2; i++) begin
        done_m[k][i] = 1'b0;
        if (stop[i]) begin
          act_m[k][i] = 1'b0;
          n_m[k][i]   = 0;
        end else if (start[i]) begin
          act_m[k][i]  = 1'b1;
          mode_m[k][i] = periodic[i];
          rel_m[k][i]  = int'(load_value[i*8 +: 8]);
          n_m[k][i]    = 0;
        end else if (act_m[k][i] && tin) begin
          n_m[k][i]++;
          if (n_m[k][i] % (rel_m[k][i] + 1) == 0) begin
            done_m[k][i] = 1'b1;
            if (!mode_m[k][i]) begin
              act_m[k][i] = 1'b0;
              n_m[k][i]   = 0;
            end
          end
        end
      end
      tick_m[k] = (edges % presc[k] == 0);
    end
  endfunction

  task automatic compare_all();
    for (int k = 0; k < 2; k++) begin
      check($sformatf("p%0d tick", presc[k]), 32'(k ? tick_b : tick_a), 32'(tick_m[k]));
      for (int i = 0; i < 2; i++) begin
        int exp_cnt;
        exp_cnt = act_m[k][i] ? n_m[k][i] % (rel_m[k][i] + 1) : 0;
        check($sformatf("p%0d ch%0d busy", presc[k], i),
              32'(k ? busy_b[i] : busy_a[i]), 32'(act_m[k][i]));
        check($sformatf("p%0d ch%0d done", presc[k], i),
              32'(k ? done_b[i] : done_a[i]), 32'(done_m[k][i]));
        check($sformatf("p%0d ch%0d count", presc[k], i),
              32'(k ? count_b[i*8 +: 8] : count_a[i*8 +: 8]), 32'(exp_cnt));
      end
    end
  endtask

  // Inputs change at negedge, DUT and model both consume them at the following posedge.
  task automatic cycle(input logic [1:0] st, input logic [1:0] sp,
                       input logic [1:0] per, input logic [15:0] ld);
    start = st; stop = sp; periodic = per; load_value = ld;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n, input logic [15:0] ld);
    for (int j = 0; j < n; j++) cycle(2'b00, 2'b00, 2'b00, ld);
  endtask

  task automatic random_phase(input int n);
    for (int j = 0; j < n; j++) begin
      logic [1:0]  st, sp, per;
      logic [15:0] ld;
      for (int i = 0; i < 2; i++) begin
        st[i]  = ($urandom_range(0, 19) == 0);
        sp[i]  = ($urandom_range(0, 39) == 0);
        per[i] = $urandom_range(0, 1);
        ld[i*8 +: 8] = ($urandom_range(0, 15) == 0) ? 8'hff : 8'($urandom_range(0, 12));
      end
      cycle(st, sp, per, ld);
    end
  endtask

  initial begin
    reset = 1'b0; start = '0; stop = '0; periodic = '0; load_value = '0;
    model_reset();
    repeat (3) @(negedge clk);
    compare_all();
    reset = 1'b1;

    // one-shot ch0, load 3
    cycle(2'b01, 2'b00, 2'b00, {8'd0, 8'd3});
    idle(8, 16'h0000);
    // periodic ch1, load 2, load_value changed mid-run, then restart picks up 9
    cycle(2'b10, 2'b00, 2'b10, {8'd2, 8'd0});
    idle(16, {8'd9, 8'd0});
    cycle(2'b10, 2'b00, 2'b10, {8'd9, 8'd0});
    idle(25, {8'd2, 8'd0});
    cycle(2'b00, 2'b10, 2'b00, 16'h0000);
    // stop mid-run, start+stop together, restart mid-run
    cycle(2'b01, 2'b00, 2'b00, {8'd0, 8'd5});
    idle(3, {8'd0, 8'd5});
    cycle(2'b00, 2'b01, 2'b00, {8'd0, 8'd5});
    cycle(2'b01, 2'b01, 2'b00, {8'd0, 8'd5});
    idle(2, {8'd0, 8'd5});
    cycle(2'b01, 2'b00, 2'b00, {8'd0, 8'd5});
    idle(4, {8'd0, 8'd5});
    cycle(2'b01, 2'b00, 2'b00, {8'd0, 8'd5});
    idle(12, {8'd0, 8'd5});
    // load 0 periodic, then concurrent loads 1 and 4
    cycle(2'b01, 2'b00, 2'b01, 16'h0000);
    idle(6, 16'h0000);
    cycle(2'b11, 2'b00, 2'b11, {8'd4, 8'd1});
    idle(30, 16'h0000);
    cycle(2'b00, 2'b11, 2'b00, 16'h0000);
    // max terminal count, one-shot
    cycle(2'b01, 2'b00, 2'b00, {8'd0, 8'hff});
    idle(260, 16'h0000);

    random_phase(1500);

    // asynchronous reset between edges while both channels run
    cycle(2'b11, 2'b00, 2'b11, {8'd7, 8'd7});
    idle(3, 16'h0000);
    #2 reset = 1'b0;
    #1;
    model_reset();
    compare_all();
    @(negedge clk);
    compare_all();
    reset = 1'b1;
    idle(10, {8'd3, 8'd3});

    random_phase(400);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
